// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: priority next-PC select plus a small
// circular return-address stack fed by predecode call/return hints.
module pc_sequencer #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] STEP      = XLEN'(4),
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        trap,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  input  logic                        hold,
  input  logic                        call_push,
  input  logic                        ret_pop,
  output logic [XLEN-1:0]             pc_out,
  output logic [XLEN-1:0]             pc_next,
  output logic [XLEN-1:0]             pc_prev,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_underflow
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pc_prev_q, pc_prev_d;
  logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
  logic [CNT_W-1:0] ras_count_q, ras_count_d;
  logic             ras_underflow_q, ras_underflow_d;
  logic [XLEN-1:0]  ras_mem_q [RAS_DEPTH];
  logic [XLEN-1:0]  ras_mem_d [RAS_DEPTH];

  logic [XLEN-1:0]  pc_seq;
  logic [XLEN-1:0]  ras_top;
  logic             ras_empty;
  logic             ras_en;
  logic             advance;

  // Next-PC priority select and RAS update
  always_comb begin
    pc_seq          = pc_q + STEP;
    ras_top         = ras_mem_q[ras_ptr_q];
    ras_empty       = (ras_count_q == '0);
    ras_en          = !trap && !redirect_valid && !hold;
    advance         = trap || redirect_valid || !hold;
    pc_d            = pc_seq;
    pc_prev_d       = advance ? pc_q : pc_prev_q;
    ras_ptr_d       = ras_ptr_q;
    ras_count_d     = ras_count_q;
    ras_underflow_d = 1'b0;
    ras_mem_d       = ras_mem_q;

    if (trap) begin
      pc_d = TRAP_VEC;
    end else if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (hold) begin
      pc_d = pc_q;
    end else if (ret_pop && !ras_empty) begin
      pc_d = ras_top;
    end

    if (ras_en) begin
      if (call_push && ret_pop) begin
        // Tail call: the return slot is reused in place
        ras_mem_d[ras_ptr_q] = pc_seq;
        if (ras_empty) begin
          ras_count_d = CNT_W'(1);
        end
      end else if (call_push) begin
        ras_ptr_d            = ras_ptr_q + PTR_W'(1);
        ras_mem_d[ras_ptr_d] = pc_seq;
        if (ras_count_q != CNT_W'(RAS_DEPTH)) begin
          ras_count_d = ras_count_q + CNT_W'(1);
        end
      end else if (ret_pop) begin
        if (ras_empty) begin
          ras_underflow_d = 1'b1;
        end else begin
          ras_ptr_d   = ras_ptr_q - PTR_W'(1);
          ras_count_d = ras_count_q - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q            <= RESET_VEC;
      pc_prev_q       <= '0;
      ras_ptr_q       <= '0;
      ras_count_q     <= '0;
      ras_underflow_q <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      pc_prev_q       <= pc_prev_d;
      ras_ptr_q       <= ras_ptr_d;
      ras_count_q     <= ras_count_d;
      ras_underflow_q <= ras_underflow_d;
    end
  end

  // Entry contents need no reset; the count gates every read
  always_ff @(posedge clk) begin
    ras_mem_q <= ras_mem_d;
  end

  assign pc_out        = pc_q;
  assign pc_next       = rst ? pc_d : RESET_VEC;
  assign pc_prev       = pc_prev_q;
  assign ras_count     = ras_count_q;
  assign ras_underflow = ras_underflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, then random traffic checked
// against a queue-based reference model.
module tb_pc_sequencer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, trap, redirect_valid, hold, call_push, ret_pop;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out, pc_next, pc_prev;
  logic [2:0]  ras_count;
  logic        ras_underflow;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_pc, m_prev;
  logic [31:0] m_q[$];
  logic        m_uf;

  typedef struct {
    logic        r, t, rv, h, cp, rp;
    logic [31:0] rpc;
    logic [31:0] e_pc, e_prev;
    int          e_cnt;
    logic        e_uf;
  } vec_t;

  vec_t tbl[$];

  pc_sequencer dut (
    .clk(clk), .rst(rst), .trap(trap), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .hold(hold), .call_push(call_push), .ret_pop(ret_pop),
    .pc_out(pc_out), .pc_next(pc_next), .pc_prev(pc_prev),
    .ras_count(ras_count), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, t, rv, input logic [31:0] rpc,
                              input logic h, cp, rp, input logic [31:0] e_pc, e_prev,
                              input int e_cnt, input logic e_uf);
    vec_t v;
    v.r = r; v.t = t; v.rv = rv; v.rpc = rpc; v.h = h; v.cp = cp; v.rp = rp;
    v.e_pc = e_pc; v.e_prev = e_prev; v.e_cnt = e_cnt; v.e_uf = e_uf;
    return v;
  endfunction

  function automatic logic [31:0] model_next(input logic t, rv, input logic [31:0] rpc,
                                             input logic h, rp);
    if (t)  return 32'h0000_0100;
    if (rv) return rpc;
    if (h)  return m_pc;
    if (rp && m_q.size() != 0) return m_q[m_q.size()-1];
    return m_pc + 32'd4;
  endfunction

  // One clock: predict, check pc_next, clock, update model, check registers
  task automatic cycle(input logic r, t, rv, input logic [31:0] rpc, input logic h, cp, rp);
    logic [31:0] nxt;
    logic        uf;
    rst = r; trap = t; redirect_valid = rv; redirect_pc = rpc;
    hold = h; call_push = cp; ret_pop = rp;
    #1;
    nxt = model_next(t, rv, rpc, h, rp);
    if (r) chk("pc_next", pc_next, nxt);
    @(posedge clk);
    if (!r) begin
      m_pc = 32'h0; m_prev = 32'h0; m_q.delete(); m_uf = 1'b0;
    end else begin
      uf = 1'b0;
      if (!t && !rv && !h) begin
        if (cp && rp) begin
          if (m_q.size() == 0) m_q.push_back(m_pc + 32'd4);
          else m_q[m_q.size()-1] = m_pc + 32'd4;
        end else if (cp) begin
          m_q.push_back(m_pc + 32'd4);
          if (m_q.size() > DEPTH) void'(m_q.pop_front());
        end else if (rp) begin
          if (m_q.size() != 0) void'(m_q.pop_back());
          else uf = 1'b1;
        end
      end
      if (t || rv || !h) m_prev = m_pc;
      m_pc = nxt;
      m_uf = uf;
    end
    #1;
    chk("pc_out", pc_out, m_pc);
    chk("pc_prev", pc_prev, m_prev);
    chk("ras_count", 32'(ras_count), 32'(m_q.size()));
    chk("ras_underflow", 32'(ras_underflow), 32'(m_uf));
  endtask

  initial begin
    rst = 1'b0; trap = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    hold = 1'b0; call_push = 1'b0; ret_pop = 1'b0;
    m_pc = '0; m_prev = '0; m_uf = 1'b0;

    //              r  t  rv rpc           h  cp rp  pc            prev          cnt uf
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h4,        32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h8,        32'h4,        0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'hC,        32'h8,        0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h10,       32'hC,        0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 0, 0, 32'h10,       32'hC,        0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 0, 0, 32'h10,       32'hC,        0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 0, 0, 32'h10,       32'hC,        0, 0));
    tbl.push_back(mk(1, 1, 1, 32'h40,       1, 0, 0, 32'h100,      32'h10,       0, 0));
    tbl.push_back(mk(1, 0, 1, 32'h20,       0, 0, 0, 32'h20,       32'h100,      0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 1, 0, 32'h24,       32'h20,       1, 0));
    tbl.push_back(mk(1, 0, 1, 32'h80,       0, 0, 0, 32'h80,       32'h24,       1, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1, 32'h24,       32'h80,       0, 0));
    tbl.push_back(mk(1, 0, 1, 32'h0,        0, 0, 0, 32'h0,        32'h24,       0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 1, 0, 32'h4,        32'h0,        1, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 1, 0, 32'h8,        32'h4,        2, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 1, 0, 32'hC,        32'h8,        3, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 1, 0, 32'h10,       32'hC,        4, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 1, 0, 32'h14,       32'h10,       4, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1, 32'h14,       32'h14,       3, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1, 32'h10,       32'h14,       2, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1, 32'hC,        32'h10,       1, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1, 32'h8,        32'hC,        0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1, 32'hC,        32'h8,        0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1, 32'h10,       32'hC,        0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h14,       32'h10,       0, 0));
    tbl.push_back(mk(1, 0, 1, 32'h20,       0, 0, 0, 32'h20,       32'h14,       0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 1, 0, 32'h24,       32'h20,       1, 0));
    tbl.push_back(mk(1, 0, 1, 32'h50,       0, 0, 0, 32'h50,       32'h24,       1, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 1, 1, 32'h24,       32'h50,       1, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1, 32'h54,       32'h24,       0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 1, 1, 32'h58,       32'h54,       1, 0));
    tbl.push_back(mk(1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 32'h58,      1, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'hFFFF_FFFC, 1, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 1, 0, 32'h4,        32'h0,        2, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 1, 0, 32'h8,        32'h4,        3, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 0, 32'h0,        32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1, 32'h4,        32'h0,        0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h8,        32'h4,        0, 0));
    tbl.push_back(mk(1, 0, 1, 32'h200,      0, 1, 0, 32'h200,      32'h8,        0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 0, 1, 32'h200,      32'h8,        0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].r, tbl[i].t, tbl[i].rv, tbl[i].rpc, tbl[i].h, tbl[i].cp, tbl[i].rp);
      chk($sformatf("vec%0d_pc", i), pc_out, tbl[i].e_pc);
      chk($sformatf("vec%0d_prev", i), pc_prev, tbl[i].e_prev);
      chk($sformatf("vec%0d_cnt", i), 32'(ras_count), 32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_uf", i), 32'(ras_underflow), 32'(tbl[i].e_uf));
    end

    // Random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 1023));
      cycle(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 9) == 0),
            rpc,
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the pipelined core's fetch stage, replacing the fixed 32-bit increment-by-one counter. It selects the next fetch address by fixed priority from trap, branch redirect, stall hold, return-address-stack (RAS) prediction and sequential increment. It keeps a registered previous PC for the decode stage. It owns a small circular RAS driven by call/return hints from predecode.

## Interface
Parameters:
- XLEN, 32, address width in bits.
- STEP, 4, sequential increment in bytes; must satisfy 0 < STEP < 2^XLEN.
- RESET_VEC, 0, pc_out value after reset.
- TRAP_VEC, 32'h0000_0100, target on trap; truncated to XLEN.
- RAS_DEPTH, 4, RAS entries; a power of two, at least 2.

Ports (reset rst, synchronous, active-low; clock clk):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-low reset.
- trap  in  1  force the next PC to TRAP_VEC.
- redirect_valid  in  1  branch or jump resolved; take redirect_pc.
- redirect_pc  in  XLEN  redirect target.
- hold  in  1  stall; PC and RAS keep their values.
- call_push  in  1  current instruction is a call; push pc_out+STEP.
- ret_pop  in  1  current instruction is a return; predict the RAS top.
- pc_out  out  XLEN  registered current fetch PC.
- pc_next  out  XLEN  combinational value pc_out takes at the next edge.
- pc_prev  out  XLEN  registered pc_out from the last advancing cycle.
- ras_count  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries.
- ras_underflow  out  1  registered one-cycle pulse: a pop was attempted with an empty RAS.

## Operation
- The next-PC source is chosen by priority, highest first:
  - trap -> TRAP_VEC.
  - redirect_valid -> redirect_pc.
  - hold -> pc_out.
  - ret_pop and ras_count != 0 -> RAS top.
  - otherwise -> pc_out + STEP.
- An advance cycle is any cycle with trap, redirect_valid or !hold asserted. On an advance cycle, pc_prev <= pc_out. pc_prev is unchanged while holding.
- RAS operations take effect only on cycles with !trap, !redirect_valid and !hold. In every other cycle call_push and ret_pop are ignored and ras_underflow is 0.
- Push only:
  - Write pc_out+STEP at the top pointer + 1 and advance the pointer.
  - ras_count increments, saturating at RAS_DEPTH.
  - When full, the oldest entry is silently overwritten (circular buffer).
- Pop only with ras_count > 0: the PC takes the top entry, the pointer decrements and ras_count decrements.
- Pop only with ras_count == 0: the PC takes pc_out+STEP, the RAS is unchanged and ras_underflow pulses next cycle.
- Push and pop in the same cycle (tail call):
  - The PC takes the old top, or pc_out+STEP if the RAS is empty.
  - The top entry is overwritten with pc_out+STEP.
  - ras_count is unchanged, except that an empty RAS becomes count 1 with no underflow pulse.
- Arithmetic: all additions are modulo 2^XLEN. pc_out = 2^XLEN - STEP advances to 0 with no flag.
- redirect_pc is used unmodified; there is no alignment check.
- Reset (rst == 0 at an edge):
  - pc_out = RESET_VEC, pc_prev = 0, ras_count = 0, ras_underflow = 0.
  - The RAS pointer goes to 0. Entry contents are don't-care.
  - Reset overrides all other inputs, including during a hold or a full RAS.

## Timing
- One-cycle latency: inputs sampled at edge N determine pc_out after edge N.
- pc_next is a combinational function of the inputs and current state, and equals pc_out after the next edge.
- pc_next is combinational from trap, redirect_valid, redirect_pc, hold, call_push and ret_pop. Downstream logic must register it before any long path.
- On the first edge after rst deasserts, pc_out advances to RESET_VEC+STEP unless hold is asserted.
- ras_underflow is high for exactly one cycle per offending pop. Back-to-back failed pops give back-to-back pulses.
- There are no handshakes; hold is level-sensitive. A trap or redirect asserted during hold takes effect immediately.

## Test plan
- Reset then increment: hold rst=0 for 2 cycles, then release with all inputs 0 -> pc_out reads 0, 4, 8, 12 and pc_prev lags by one cycle, starting from 0.
- Hold and priority:
  - hold for 3 cycles at pc_out=0x10 -> pc_out stays 0x10 and pc_prev is unchanged.
  - trap together with redirect_valid (redirect_pc=0x40) during hold -> pc_out=0x100.
- RAS round trip:
  - call_push at pc_out=0x20 -> ras_count=1.
  - ret_pop later at pc_out=0x80 -> pc_out=0x24 and ras_count=0.
- RAS overflow: 5 pushes at PCs 0x0, 0x4, 0x8, 0xC, 0x10 -> ras_count=4.
- RAS pops after overflow: 4 pops return 0x14, 0x10, 0xC, 0x8 in that order; a 5th pop -> pc_out+4 and ras_underflow=1 for one cycle.
- Tail call and wrap:
  - push and pop together with top=0x24 at pc_out=0x50 -> pc_out=0x24, top=0x54, ras_count unchanged.
  - redirect to 0xFFFF_FFFC -> next pc_out=0x0000_0000.
- Reset mid-operation: rst=0 with ras_count=3 and hold=1 -> pc_out=RESET_VEC and ras_count=0.
- Pop after reset: ret_pop right after release -> sequential increment and an underflow pulse.
